shift_fir_filter: RTL and testbench
===================================

// Module: shift_fir_filter
//
// PURPOSE
//   Parametrised multi-tap shift-weighted FIR filter, the successor of the fixed 2-tap shift filter.
//   Keeps a TAPS-deep delay line of valid input samples and sums per-tap right-shifted terms.
//   Mode 0: the per-tap shift amounts are runtime-configurable. Mode 1: exact moving average.
//   Sits on the sample path between the input sampler and downstream result logic; no backpressure.
//
// PARAMETERS
//   IN_W   4  sample width (unsigned)
//   TAPS   4  delay-line depth; power of 2, >= 2
//   SH_W   2  width of each per-tap shift amount
//   OUT_W  8  output width; must be >= IN_W + log2(TAPS), so the sum never overflows
//
// PORTS
//   clk         in   1            clock; all state updates on the rising edge
//   rst         in   1            reset, asynchronous, active-high
//   x_is_valid  in   1            x carries a new sample this cycle
//   x           in   IN_W         input sample
//   flush       in   1            synchronous clear of the delay line
//   mode        in   1            0 = shift-weighted sum, 1 = moving average
//   cfg_we      in   1            load cfg_sh into the shift register
//   cfg_sh      in   TAPS*SH_W    per-tap shifts; slice [i*SH_W +: SH_W] applies to tap i
//   y           out  OUT_W        filter result
//   y_valid     out  1            one-cycle pulse: y is new
//
// BEHAVIOUR
//   Reset (async, any time, also mid-stream):
//     - y = 0, y_valid = 0.
//     - All delay-line taps d[0..TAPS-1] = 0; all shift amounts sh[i] = 0.
//     - Release is synchronous to the next edge; the first edge after release already accepts input.
//   Delay line: at an edge with x_is_valid = 1:
//     - d[0] <= x, d[i] <= d[i-1]. d[0] is the newest sample. No change when x_is_valid = 0.
//   Flush: at an edge with flush = 1:
//     - All d[i] <= 0.
//     - If x_is_valid = 1 at the same edge, the result is d[0] = x and the other taps 0 (flush, then accept).
//     - flush alone does not raise y_valid.
//   Config: at an edge with cfg_we = 1, sh[i] <= cfg_sh slice i.
//     - Applies to every y computed at later edges; the y of a sample accepted at that same edge uses the new shifts.
//   Output stage: if a sample is accepted at edge N, then at edge N+1:
//     - y_valid <= 1.
//     - mode 0: y <= SUM_i (d[i] >> sh[i]).
//     - mode 1: y <= (SUM_i d[i]) >> log2(TAPS), using floor; sh ignored.
//     - All terms are zero-extended to OUT_W before the add; no truncation is possible given the OUT_W rule.
//     - mode is sampled at edge N+1.
//   Latency and timing:
//     - Latency: one cycle from the accepting edge to y/y_valid. Back-to-back valids give back-to-back y_valid.
//     - With no sample accepted at edge N, y_valid <= 0 at N+1 and y holds its last value.
//   Startup: the first TAPS-1 results after reset or flush include zero taps (no warm-up suppression).
//   Implementation: the adder tree is combinational on registered taps; one output register stage only.
//
// TESTING (TAPS=4, IN_W=4, SH_W=2, OUT_W=8)
//   1. mode 0, sh all 0, feed 1,2,3,4 on consecutive cycles -> y = 1,3,6,10 with y_valid high 4 cycles, starting 1 cycle later.
//   2. mode 1, feed 15,15,15,15 -> y = 3,7,11,15; then valid low 3 cycles -> y_valid 0, y holds 15.
//   3. cfg_sh with sh[0..3] = 0,1,2,3, mode 0, feed 8,8,8,8 -> y = 8,12,14,15.
//   4. After test 1, flush together with x=5 valid -> y = 5; then feed 5 -> y = 10.
//   5. Assert rst mid-stream between clock edges -> y and y_valid go to 0 immediately; after release, feed 7 -> y = 7.
//   6. cfg_we at the same edge as a valid sample -> that sample's y already uses the new shifts.
//      Setup: sh all 0 at sample 8, then sh all 1 together with the next sample 8 -> y = 8.

Source files
------------

// File: rtl/shift_fir_filter.sv
// Multi-tap shift-weighted FIR filter.
// Keeps a TAPS-deep delay line of accepted samples and, one cycle after each
// accepted sample, outputs either a sum of per-tap right-shifted taps (mode 0)
// or the exact floor moving average of the taps (mode 1).
module shift_fir_filter #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned TAPS  = 4,
  parameter int unsigned SH_W  = 2,
  parameter int unsigned OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x_is_valid,
  input  logic [IN_W-1:0]        x,
  input  logic                   flush,
  input  logic                   mode,
  input  logic                   cfg_we,
  input  logic [TAPS*SH_W-1:0]   cfg_sh,
  output logic [OUT_W-1:0]       y,
  output logic                   y_valid
);

  localparam int unsigned LOG2_TAPS = $clog2(TAPS);

  // Delay line (index 0 = newest sample) and per-tap shift amounts
  logic [IN_W-1:0] r_d  [TAPS];
  logic [SH_W-1:0] r_sh [TAPS];
  // A sample was accepted at the previous edge, so the output updates now
  logic            r_acc;

  // Combinational adder tree results on the registered taps
  logic [OUT_W-1:0] w_sum_sh;
  logic [OUT_W-1:0] w_sum_raw;
  logic [OUT_W-1:0] w_avg;
  logic [OUT_W-1:0] w_y_next;

  // Delay line: flush clears every tap; a simultaneous valid sample lands in tap 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_d[i] <= '0;
      end
    end else if (x_is_valid) begin
      r_d[0] <= x;
      for (int i = 1; i < TAPS; i++) begin
        r_d[i] <= flush ? '0 : r_d[i-1];
      end
    end else if (flush) begin
      for (int i = 0; i < TAPS; i++) begin
        r_d[i] <= '0;
      end
    end
  end

  // Shift configuration register, loaded slice by slice from cfg_sh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_sh[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < TAPS; i++) begin
        r_sh[i] <= cfg_sh[i*SH_W +: SH_W];
      end
    end
  end

  // Remember acceptance so the output stage fires exactly one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 1'b0;
    end else begin
      r_acc <= x_is_valid;
    end
  end

  // Shifted and unshifted tap sums; terms zero-extended to OUT_W before adding
  always_comb begin
    w_sum_sh  = '0;
    w_sum_raw = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_sum_sh  = w_sum_sh  + OUT_W'(r_d[i] >> r_sh[i]);
      w_sum_raw = w_sum_raw + OUT_W'(r_d[i]);
    end
  end

  // Mode select: floor average divides the raw sum by the power-of-2 tap count
  always_comb begin
    w_avg    = w_sum_raw >> LOG2_TAPS;
    w_y_next = mode ? w_avg : w_sum_sh;
  end

  // Output register: new y with a one-cycle y_valid pulse, otherwise hold y
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= r_acc;
      if (r_acc) begin
        y <= w_y_next;
      end
    end
  end

endmodule

// File: tb/tb_shift_fir_filter.sv
// Self-checking bench for shift_fir_filter (TAPS=4, IN_W=4, SH_W=2, OUT_W=8).
// Expected results are queued when a sample is driven and popped when y_valid is due.
module tb_shift_fir_filter;

  logic       clk;
  logic       rst;
  logic       x_is_valid;
  logic [3:0] x;
  logic       flush;
  logic       mode;
  logic       cfg_we;
  logic [7:0] cfg_sh;
  logic [7:0] y;
  logic       y_valid;

  int n_cmp;
  int n_bad;
  logic [7:0] sb_q[$];
  bit         pend;
  logic [7:0] last_y;

  shift_fir_filter #(.IN_W(4), .TAPS(4), .SH_W(2), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .x_is_valid(x_is_valid), .x(x), .flush(flush),
    .mode(mode), .cfg_we(cfg_we), .cfg_sh(cfg_sh), .y(y), .y_valid(y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, let one rising edge pass, then settle 1 time unit after it
  task automatic cycle(input bit v, input logic [3:0] xv, input bit fl,
                       input bit we, input logic [7:0] sh);
    x_is_valid = v;
    x          = xv;
    flush      = fl;
    cfg_we     = we;
    cfg_sh     = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (y !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_y: got %0d want 0", y);
    end
    n_cmp++;
    if (y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_y_valid: got %b want 0", y_valid);
    end
  endtask

  // Feed 1,2,3,4 with all shifts 0 -> 1,3,6,10, then idle
  task automatic test_sum_unshifted();
    logic [3:0] stim [6];
    bit         vld  [6];
    logic [7:0] e;
    stim = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
    vld  = '{1, 1, 1, 1, 0, 0};
    mode = 1'b0;
    sb_q.push_back(8'd1); sb_q.push_back(8'd3);
    sb_q.push_back(8'd6); sb_q.push_back(8'd10);
    for (int i = 0; i < 6; i++) begin
      cycle(vld[i], stim[i], 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (pend) begin
        e = sb_q.pop_front();
        last_y = e;
        if (y_valid !== 1'b1 || y !== e) begin
          n_bad++;
          $display("FAIL sum_unshifted[%0d]: got y=%0d v=%b want y=%0d v=1", i, y, y_valid, e);
        end
      end else if (y_valid !== 1'b0 || y !== last_y) begin
        n_bad++;
        $display("FAIL sum_unshifted_idle[%0d]: got y=%0d v=%b want y=%0d v=0", i, y, y_valid, last_y);
      end
      pend = vld[i];
    end
  endtask

  // Flush together with a valid 5 -> 5, then 5 again -> 10
  task automatic test_flush_accept();
    logic [7:0] e;
    bit         fl [3];
    bit         vld[3];
    fl  = '{1, 0, 0};
    vld = '{1, 1, 0};
    sb_q.push_back(8'd5); sb_q.push_back(8'd10);
    for (int i = 0; i < 3; i++) begin
      cycle(vld[i], 4'd5, fl[i], 1'b0, 8'h00);
      n_cmp++;
      if (pend) begin
        e = sb_q.pop_front();
        last_y = e;
        if (y_valid !== 1'b1 || y !== e) begin
          n_bad++;
          $display("FAIL flush_accept[%0d]: got y=%0d v=%b want y=%0d v=1", i, y, y_valid, e);
        end
      end else if (y_valid !== 1'b0 || y !== last_y) begin
        n_bad++;
        $display("FAIL flush_accept_idle[%0d]: got y=%0d v=%b want y=%0d v=0", i, y, y_valid, last_y);
      end
      pend = vld[i];
    end
  endtask

  // Flush alone, then mode 1 with 15,15,15,15 -> 3,7,11,15 and hold for 3 idle cycles
  task automatic test_average();
    logic [7:0] e;
    bit         vld[8];
    bit         fl [8];
    vld = '{0, 1, 1, 1, 1, 0, 0, 0};
    fl  = '{1, 0, 0, 0, 0, 0, 0, 0};
    mode = 1'b1;
    sb_q.push_back(8'd3); sb_q.push_back(8'd7);
    sb_q.push_back(8'd11); sb_q.push_back(8'd15);
    for (int i = 0; i < 8; i++) begin
      cycle(vld[i], 4'd15, fl[i], 1'b0, 8'h00);
      n_cmp++;
      if (pend) begin
        e = sb_q.pop_front();
        last_y = e;
        if (y_valid !== 1'b1 || y !== e) begin
          n_bad++;
          $display("FAIL average[%0d]: got y=%0d v=%b want y=%0d v=1", i, y, y_valid, e);
        end
      end else if (y_valid !== 1'b0 || y !== last_y) begin
        n_bad++;
        $display("FAIL average_idle[%0d]: got y=%0d v=%b want y=%0d v=0", i, y, y_valid, last_y);
      end
      pend = vld[i];
    end
    mode = 1'b0;
  endtask

  // Shifts 0,1,2,3 with 8,8,8,8 -> 8,12,14,15
  task automatic test_cfg_shift();
    logic [7:0] e;
    bit         vld[6];
    vld = '{0, 1, 1, 1, 1, 0};
    sb_q.push_back(8'd8); sb_q.push_back(8'd12);
    sb_q.push_back(8'd14); sb_q.push_back(8'd15);
    for (int i = 0; i < 6; i++) begin
      cycle(vld[i], 4'd8, i == 0, i == 0, 8'b11_10_01_00);
      n_cmp++;
      if (pend) begin
        e = sb_q.pop_front();
        last_y = e;
        if (y_valid !== 1'b1 || y !== e) begin
          n_bad++;
          $display("FAIL cfg_shift[%0d]: got y=%0d v=%b want y=%0d v=1", i, y, y_valid, e);
        end
      end else if (y_valid !== 1'b0 || y !== last_y) begin
        n_bad++;
        $display("FAIL cfg_shift_idle[%0d]: got y=%0d v=%b want y=%0d v=0", i, y, y_valid, last_y);
      end
      pend = vld[i];
    end
  endtask

  // New shifts written at the accepting edge already apply to that sample
  task automatic test_cfg_same_edge();
    logic [7:0] e;
    bit         vld[4];
    bit         we [4];
    logic [7:0] shv[4];
    vld = '{0, 1, 1, 0};
    we  = '{1, 0, 1, 0};
    shv = '{8'h00, 8'h00, 8'h55, 8'h00};
    sb_q.push_back(8'd8); sb_q.push_back(8'd8);
    for (int i = 0; i < 4; i++) begin
      cycle(vld[i], 4'd8, i == 0, we[i], shv[i]);
      n_cmp++;
      if (pend) begin
        e = sb_q.pop_front();
        last_y = e;
        if (y_valid !== 1'b1 || y !== e) begin
          n_bad++;
          $display("FAIL cfg_same_edge[%0d]: got y=%0d v=%b want y=%0d v=1", i, y, y_valid, e);
        end
      end else if (y_valid !== 1'b0 || y !== last_y) begin
        n_bad++;
        $display("FAIL cfg_same_edge_idle[%0d]: got y=%0d v=%b want y=%0d v=0", i, y, y_valid, last_y);
      end
      pend = vld[i];
    end
  endtask

  // Asynchronous reset mid-stream; afterwards taps and shifts are cleared, 7 -> 7
  task automatic test_reset_midstream();
    logic [7:0] e;
    cycle(1'b1, 4'd3, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 4'd4, 1'b0, 1'b0, 8'h00);
    x_is_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (y !== 8'd0 || y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got y=%0d v=%b want y=0 v=0", y, y_valid);
    end
    sb_q.delete();
    pend   = 1'b0;
    last_y = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(8'd7);
    for (int i = 0; i < 3; i++) begin
      cycle(i == 0, 4'd7, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (pend) begin
        e = sb_q.pop_front();
        last_y = e;
        if (y_valid !== 1'b1 || y !== e) begin
          n_bad++;
          $display("FAIL reset_release[%0d]: got y=%0d v=%b want y=%0d v=1", i, y, y_valid, e);
        end
      end else if (y_valid !== 1'b0 || y !== last_y) begin
        n_bad++;
        $display("FAIL reset_release_idle[%0d]: got y=%0d v=%b want y=%0d v=0", i, y, y_valid, last_y);
      end
      pend = (i == 0);
    end
  endtask

  // Random back-to-back traffic with flushes and config writes against a reference model
  task automatic test_back_to_back(input bit md);
    logic [3:0] m_d [4];
    logic [1:0] m_sh[4];
    logic [7:0] e;
    logic [7:0] acc;
    bit         v, fl, we;
    logic [3:0] xv;
    logic [7:0] shv;
    mode = md;
    for (int i = 0; i < 41; i++) begin
      v   = (i < 40) && ($urandom_range(3) != 0);
      fl  = (i == 0) || ($urandom_range(9) == 0);
      we  = (i == 0) || ($urandom_range(7) == 0);
      xv  = 4'($urandom_range(15));
      shv = 8'($urandom_range(255));
      if (fl) for (int k = 0; k < 4; k++) m_d[k] = 4'd0;
      if (we) for (int k = 0; k < 4; k++) m_sh[k] = shv[2*k +: 2];
      if (v) begin
        for (int k = 3; k > 0; k--) m_d[k] = m_d[k-1];
        m_d[0] = xv;
        acc = 8'd0;
        for (int k = 0; k < 4; k++) begin
          acc = acc + (md ? 8'(m_d[k]) : 8'(m_d[k] >> m_sh[k]));
        end
        sb_q.push_back(md ? (acc / 8'd4) : acc);
      end
      cycle(v, xv, fl, we, shv);
      n_cmp++;
      if (pend) begin
        e = sb_q.pop_front();
        last_y = e;
        if (y_valid !== 1'b1 || y !== e) begin
          n_bad++;
          $display("FAIL back_to_back_m%0d[%0d]: got y=%0d v=%b want y=%0d v=1", md, i, y, y_valid, e);
        end
      end else if (y_valid !== 1'b0 || y !== last_y) begin
        n_bad++;
        $display("FAIL back_to_back_m%0d_idle[%0d]: got y=%0d v=%b want y=%0d v=0", md, i, y, y_valid, last_y);
      end
      pend = v;
    end
    mode = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; pend = 1'b0; last_y = 8'd0;
    rst = 1'b1; x_is_valid = 1'b0; x = 4'd0; flush = 1'b0;
    mode = 1'b0; cfg_we = 1'b0; cfg_sh = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_sum_unshifted();
    test_flush_accept();
    test_average();
    test_cfg_shift();
    test_cfg_same_edge();
    test_reset_midstream();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
